rca_multicycle_stager: RTL
==========================

# rca_multicycle_stager

Handshake and timing stage wrapped around the combinational 35-bit ripple-carry adder. It accepts operand pairs over a valid/ready interface and registers them to drive the adder. It holds the operands stable for a parameterised number of cycles so the ripple path is a declared multicycle path, then captures the 36-bit sum and presents it downstream over a second valid/ready interface.

## Interface
- WIDTH, 35, operand width; the adder result is WIDTH+1 bits.
- SETTLE_CYCLES, 3, clock edges between operand registration and result capture; legal range ≥1; elaboration error if 0.
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous and active-low.
- i_valid  input  1  upstream operand pair valid.
- o_ready  output  1  stage can accept an operand pair this cycle.
- i_add_term1  input  WIDTH  operand A from upstream.
- i_add_term2  input  WIDTH  operand B from upstream.
- o_add_term1  output  WIDTH  registered operand A, wired to the adder's i_add_term1.
- o_add_term2  output  WIDTH  registered operand B, wired to the adder's i_add_term2.
- i_adder_result  input  WIDTH+1  adder o_result (carry-out in the MSB).
- o_valid  output  1  o_result is valid.
- i_ready  input  1  downstream accepts o_result this cycle.
- o_result  output  WIDTH+1  captured sum, with carry-out in the MSB.
- o_busy  output  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, SETTLE and HOLD. A settle counter has width clog2(SETTLE_CYCLES+1).
- **IDLE**
  - o_ready=1.
  - On i_valid: register both operands into o_add_term1/2, load the counter with SETTLE_CYCLES-1, and go to SETTLE.
- **SETTLE**
  - o_ready=0 and o_valid=0.
  - If counter==0: capture i_adder_result into o_result, set o_valid, and go to HOLD.
  - Otherwise decrement the counter.
- **HOLD**
  - o_valid=1; o_result and the operand registers are frozen.
  - o_ready=i_ready (combinational pass-through).
  - i_ready=1 and i_valid=0: clear o_valid and go to IDLE.
  - i_ready=1 and i_valid=1: accept the new pair the same cycle, clear o_valid, reload the counter, and go to SETTLE.
  - i_ready=0: stay in HOLD, regardless of i_valid.
- Operand registers change only on an accepted input. o_add_term1/2 are therefore constant from the accept edge until the capture edge, which is what makes the multicycle constraint legal.
- The stage performs no arithmetic. o_result is a bit-exact copy of i_adder_result sampled on the capture edge, and no overflow or saturation is applied. Bit WIDTH is the carry-out.
- o_result keeps its last captured value while in IDLE/SETTLE; only o_valid qualifies it.
- **Reset** (asynchronous assert, any state, including mid-SETTLE or HOLD):
  - State goes to IDLE and the counter to 0.
  - o_add_term1/2=0, o_result=0, o_valid=0, o_busy=0, o_ready=1.
  - An in-flight transaction is discarded without producing output.
- o_ready does not depend on i_valid. o_valid does not depend on i_ready.

## Timing
- If the input is accepted at edge k, the result is captured at edge k+SETTLE_CYCLES and o_valid is high after that edge.
- For SETTLE_CYCLES=1, capture happens on the first edge after the accept edge.
- Maximum throughput is one transaction per SETTLE_CYCLES+1 cycles, using the HOLD accept-and-reload path with downstream always ready.
- o_valid stays high until the edge on which i_ready=1 is sampled; o_result is stable for that whole window.
- o_busy rises on the edge after the accept and falls on the edge where HOLD exits to IDLE.

## Test plan
- **Reset values:** assert i_rst_n=0 mid-SETTLE, then release. Expect o_valid=0, o_ready=1, o_result=0, o_add_term1/2=0, and no output for the dropped transaction.
- **Basic add, SETTLE_CYCLES=3:** A=0x000000005, B=0x000000003 accepted at edge k. Expect o_add_term1/2 stable from k to k+3, o_valid rising after k+3, and o_result=0x000000008.
- **Carry-out, SETTLE_CYCLES=1:** A=0x7FFFFFFFF, B=0x000000001. Expect o_result=0x800000000 (MSB set), captured one edge after accept.
- **Back-pressure:** hold i_ready=0 for 10 cycles while i_valid=1 with new operands. Expect o_ready=0, o_result and o_add_term1/2 unchanged, and o_valid held high.
- **Back-to-back:**
  - Setup: i_valid=1 and i_ready=1 continuously with pairs (1,1), (2,2), (3,3), SETTLE_CYCLES=2.
  - Expect: results 2, 4, 6, in order, with one accept every 3 cycles and no lost or duplicated transactions.
- **Max operands:** A=B=0x7FFFFFFFF. Expect o_result=0xFFFFFFFFE.

Source files
------------

// File: rtl/rca_multicycle_stager.sv
// Valid/ready timing stage around a combinational ripple-carry adder.
// Operands are registered on accept and held for SETTLE_CYCLES edges so the
// ripple path can be constrained as a multicycle path, then the sum is
// captured and offered downstream until it is taken.
module rca_multicycle_stager #(
  parameter int WIDTH         = 35,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  output logic [WIDTH-1:0] o_add_term1,
  output logic [WIDTH-1:0] o_add_term2,
  input  logic [WIDTH:0]   i_adder_result,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_busy
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  // A zero settle time would capture on the accept edge itself, before the
  // registered operands have reached the adder.
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("rca_multicycle_stager: SETTLE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] term1_reg, term2_reg;
  logic [WIDTH:0]   result_reg;
  logic             accept;
  logic             capture;
  logic             ready_next;

  // State and settle counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state, counter and handshake decode; accept/capture strobe the datapath.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ready_next = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        if (i_valid) begin
          accept     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      HOLD: begin
        // Downstream taking the result frees the stage in the same cycle.
        ready_next = i_ready;
        if (i_ready) begin
          if (i_valid) begin
            accept     = 1'b1;
            cnt_next   = CNT_LOAD;
            state_next = SETTLE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Operand registers move only on accept; result register only on capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      term1_reg  <= '0;
      term2_reg  <= '0;
      result_reg <= '0;
    end else begin
      if (accept) begin
        term1_reg <= i_add_term1;
        term2_reg <= i_add_term2;
      end
      if (capture) begin
        result_reg <= i_adder_result;
      end
    end
  end

  assign o_ready     = ready_next;
  assign o_valid     = (state_reg == HOLD);
  assign o_busy      = (state_reg != IDLE);
  assign o_add_term1 = term1_reg;
  assign o_add_term2 = term2_reg;
  assign o_result    = result_reg;

endmodule
